// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row-multiplexed sensing, frame-level debounce, valid/ready key output.
// Define KEYPAD_REPEAT_EN to auto-repeat a held key (REPEAT_DELAY, then every REPEAT_RATE frames).
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overrun
);

  if (SCAN_DIV < 4 || SCAN_DIV > 65535 || DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  logic [15:0] div_cnt;
  logic        tick, frame_end, one, hit, emit, handshake;
  logic [3:0]  col_s1, col_s2;
  logic [1:0]  row_idx;
  logic [1:0]  acc_n, row_n, row_col, f_n;
  logic [3:0]  acc_code, f_code;
  logic [2:0]  sum_n;
  state_t      state, state_n;
  logic [3:0]  cand, cand_n, dcnt, dcnt_n, dcnt_inc;
`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rpt_cnt, rpt_cnt_n, rpt_inc;
  logic        rpt_first, rpt_first_n;
`endif

  assign tick      = (div_cnt == 16'(SCAN_DIV - 1));
  assign frame_end = tick && (row_idx == 2'd3);
  assign row       = ~(4'b0001 << row_idx);

  // Key count per row saturates at 2: anything beyond one key is a ghost-prone MULTI frame.
  always_comb begin
    row_n   = 2'd0;
    row_col = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s2[c]) begin
        if (row_n != 2'd2) row_n = row_n + 2'd1;
        row_col = 2'(c);
      end
    end
    sum_n  = {1'b0, acc_n} + {1'b0, row_n};
    f_n    = (sum_n > 3'd2) ? 2'd2 : sum_n[1:0];
    f_code = (acc_n != 2'd0) ? acc_code : {row_idx, row_col};
  end

  assign one = frame_end && (f_n == 2'd1);
  assign hit = one && (f_code == cand);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt  <= '0;
      col_s1   <= 4'hf;
      col_s2   <= 4'hf;
      row_idx  <= 2'd0;
      acc_n    <= 2'd0;
      acc_code <= 4'd0;
    end else begin
      col_s1  <= col;
      col_s2  <= col_s1;
      div_cnt <= tick ? '0 : div_cnt + 16'd1;
      if (tick) begin
        row_idx <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          acc_n    <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          acc_n    <= f_n;
          acc_code <= f_code;
        end
      end
    end
  end

  assign dcnt_inc = dcnt + 4'd1;
`ifdef KEYPAD_REPEAT_EN
  assign rpt_inc  = rpt_cnt + 16'd1;
`endif

  always_comb begin
    state_n = state;
    cand_n  = cand;
    dcnt_n  = dcnt;
    emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_n   = rpt_cnt;
    rpt_first_n = rpt_first;
`endif
    if (frame_end) begin
      case (state)
        S_IDLE: if (one) begin
          cand_n  = f_code;
          dcnt_n  = 4'd1;
          state_n = S_DEBOUNCE;
        end
        S_DEBOUNCE: begin
          if (hit) begin
            dcnt_n = dcnt_inc;
            if (dcnt_inc == 4'(DEBOUNCE_SCANS)) begin
              emit    = 1'b1;
              state_n = S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt_n   = '0;
              rpt_first_n = 1'b1;
`endif
            end
          end else if (one) begin
            cand_n = f_code;
            dcnt_n = 4'd1;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (hit) begin
`ifdef KEYPAD_REPEAT_EN
            if (rpt_inc == (rpt_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE))) begin
              emit        = 1'b1;
              rpt_cnt_n   = '0;
              rpt_first_n = 1'b0;
            end else begin
              rpt_cnt_n = rpt_inc;
            end
`endif
          end else begin
            state_n = S_RELEASE;
            dcnt_n  = 4'd1;
          end
        end
        S_RELEASE: begin
          if (hit) begin
            state_n = S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_n   = '0;
            rpt_first_n = 1'b1;
`endif
          end else begin
            dcnt_n = dcnt_inc;
            if (dcnt_inc == 4'(DEBOUNCE_SCANS)) state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign handshake = key_valid && key_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      dcnt      <= 4'd0;
      key_down  <= 1'b0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      dcnt     <= dcnt_n;
      key_down <= (state_n == S_PRESSED) || (state_n == S_RELEASE);
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= rpt_cnt_n;
      rpt_first <= rpt_first_n;
`endif
      // A pending key is never overwritten; the new one is dropped and flagged instead.
      if (emit) begin
        if (!key_valid || handshake) begin
          key_code  <= cand;
          key_valid <= 1'b1;
          if (handshake) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_ready, key_down, overrun;
  logic [15:0] pressed;
  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  int          h0;
  logic [3:0]  er;
  logic        ev;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
    .clk(clk), .rstn(rstn), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(posedge clk) if (key_valid && key_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n);
    cyc(16 * n);
  endtask

  initial begin
    key_ready = 1'b1;
    pressed   = 16'h0000;
    cyc(3);
    chk("reset_state", {row, key_code, key_valid, key_down, overrun}, {4'b1110, 4'h0, 3'b000});
    rstn = 1'b1;

    // 1: idle scan, row walks every 4 clocks
    for (int k = 1; k <= 160; k++) begin
      cyc(1);
      er = ~(4'b0001 << ((k / 4) % 4));
      chk("t1_row", row, er);
      chk("t1_flags", {key_valid, key_down, overrun}, 3'b000);
    end

    // 2: clean press of key 6
    pressed = 16'h0040;
    h0 = hs_cnt;
    frame(1); chk("t2_f1_valid", key_valid, 1'b0);
    frame(1); chk("t2_f2_valid", key_valid, 1'b0);
    frame(1);
    chk("t2_emit_valid", key_valid, 1'b1);
    chk("t2_emit_code", key_code, 4'd6);
    chk("t2_down", key_down, 1'b1);
    cyc(1);  chk("t2_pulse_end", key_valid, 1'b0);
    cyc(15); frame(1);
    chk("t2_one_pulse", hs_cnt - h0, 1);
    chk("t2_down_held", key_down, 1'b1);
    pressed = 16'h0000;
    frame(1); chk("t2_rel1_down", key_down, 1'b1);
    frame(1); chk("t2_rel2_down", key_down, 1'b1);
    frame(1); chk("t2_rel3_down", key_down, 1'b0);

    // 3: bouncing key 6, then ghost pair 0+5
    h0 = hs_cnt;
    pressed = 16'h0040; frame(1); chk("t3_b1_valid", key_valid, 1'b0);
    pressed = 16'h0000; frame(1); chk("t3_b2_idle", {key_valid, key_down}, 2'b00);
    pressed = 16'h0040; frame(1); chk("t3_b3_valid", key_valid, 1'b0);
    frame(1); chk("t3_b4_valid", key_valid, 1'b0);
    frame(1);
    chk("t3_b5_valid", key_valid, 1'b1);
    chk("t3_b5_code", key_code, 4'd6);
    pressed = 16'h0000; frame(3);
    chk("t3_one_emit", hs_cnt - h0, 1);
    chk("t3_rel_down", key_down, 1'b0);
    h0 = hs_cnt;
    pressed = 16'h0021;
    for (int i = 0; i < 10; i++) begin
      frame(1);
      chk("t3_multi", {key_valid, key_down}, 2'b00);
    end
    chk("t3_multi_none", hs_cnt - h0, 0);
    pressed = 16'h0000; frame(1);

    // 4: consumer stalled, second key dropped
    key_ready = 1'b0;
    pressed = 16'h0002; frame(3);
    chk("t4_k1", {key_valid, key_code, overrun}, {1'b1, 4'd1, 1'b0});
    pressed = 16'h0000; frame(3);
    chk("t4_k1_rel_down", key_down, 1'b0);
    pressed = 16'h0004; frame(3);
    chk("t4_k2_drop", {key_valid, key_code, overrun}, {1'b1, 4'd1, 1'b1});
    pressed = 16'h0000; frame(3);
    key_ready = 1'b1; cyc(1); key_ready = 1'b0;
    chk("t4_consume", {key_valid, overrun}, 2'b00);
    cyc(15);
    key_ready = 1'b1;

    // 5: reset during debounce with key held
    pressed = 16'h0040; frame(2);
    cyc(5);
    rstn = 1'b0;
    #1;
    chk("t5_reset_state", {row, key_code, key_valid, key_down, overrun}, {4'b1110, 4'h0, 3'b000});
    cyc(3);
    rstn = 1'b1;
    frame(1); chk("t5_f1_valid", key_valid, 1'b0);
    frame(1); chk("t5_f2_idle", {key_valid, key_down}, 2'b00);
    frame(1);
    chk("t5_f3_emit", {key_valid, key_code}, {1'b1, 4'd6});
    pressed = 16'h0000; frame(3);

    // 6: long hold of key 9
    pressed = 16'h0200;
    for (int f = 1; f <= 12; f++) begin
      frame(1);
      ev = (f == 3) || (REP && (f == 7 || f == 9 || f == 11));
      chk($sformatf("t6_frame%0d_valid", f), key_valid, ev);
      if (ev) chk($sformatf("t6_frame%0d_code", f), key_code, 4'd9);
    end
    pressed = 16'h0000; frame(3);
    chk("t6_rel_down", key_down, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
